// File: rtl/array8_sort_ctrl_pkg.sv
// Shared definitions for the 8-entry array bubble-sort controller: sizes, FSM
// encoding and the array's preset contents.
package array8_sort_ctrl_pkg;

    localparam int SORT_DEPTH = 8;
    localparam int SORT_WIDTH = 8;
    localparam int SORT_IDX_W = 3;
    localparam int SORT_CNT_W = 5;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_SETTLE = 4'd2,
        ST_RD_A   = 4'd3,
        ST_RD_B   = 4'd4,
        ST_CMP    = 4'd5,
        ST_WR_A   = 4'd6,
        ST_WR_B   = 4'd7,
        ST_NEXT   = 4'd8,
        ST_FIN    = 4'd9
    } sortState_e;

    // Entry 0 sits in the least significant byte.
    localparam logic [SORT_DEPTH*SORT_WIDTH-1:0] ARR_PRESET = {
        8'd99, 8'd13, 8'd46, 8'd120, 8'd13, 8'd85, 8'd175, 8'd236
    };

    function automatic logic [SORT_WIDTH-1:0] presetEntry(input int idx);
        return ARR_PRESET[idx*SORT_WIDTH +: SORT_WIDTH];
    endfunction

endpackage

// File: rtl/array8_sort_ctrl.sv
// Bubble-sort initiator for the 8-entry array: triggers the preset load, then
// sorts in place (ascending, stable) through the array's single rd/wr port.
module array8_sort_ctrl
    import array8_sort_ctrl_pkg::*;
#(
    parameter int DEPTH = SORT_DEPTH,
    parameter int WIDTH = SORT_WIDTH,
    parameter int IDX_W = SORT_IDX_W,
    parameter int CNT_W = SORT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] swap_count,
    output logic             arr_en,
    output logic             arr_wr_en,
    output logic [IDX_W-1:0] arr_wr_idx,
    output logic [WIDTH-1:0] arr_wr_data,
    output logic             arr_rd_en,
    output logic [IDX_W-1:0] arr_rd_idx,
    input  logic [WIDTH-1:0] arr_rd_data
);

    sortState_e       state_q;
    logic [IDX_W-1:0] j_q;
    logic [IDX_W-1:0] pass_q;
    logic [WIDTH-1:0] a_q;
    logic             passSwapped_q;

    logic [IDX_W-1:0] jNext_d;
    logic [IDX_W-1:0] lastJ_d;
    logic             lastPass_d;

    // The last compare of a pass shrinks by one each pass: the tail is already sorted.
    assign jNext_d    = j_q + 1'b1;
    assign lastJ_d    = IDX_W'(DEPTH - 2) - pass_q;
    assign lastPass_d = (pass_q == IDX_W'(DEPTH - 2));

    // Strobes default low every cycle and are set on entry to the state that owns them,
    // so each strobe is registered and high exactly during its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            j_q           <= '0;
            pass_q        <= '0;
            a_q           <= '0;
            passSwapped_q <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            swap_count    <= '0;
            arr_en        <= 1'b0;
            arr_wr_en     <= 1'b0;
            arr_wr_idx    <= '0;
            arr_wr_data   <= '0;
            arr_rd_en     <= 1'b0;
            arr_rd_idx    <= '0;
        end else begin
            arr_en    <= 1'b0;
            arr_wr_en <= 1'b0;
            arr_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_LOAD;
                        arr_en        <= 1'b1;
                        busy          <= 1'b1;
                        swap_count    <= '0;
                        pass_q        <= '0;
                        j_q           <= '0;
                        passSwapped_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    state_q    <= ST_RD_A;
                    arr_rd_en  <= 1'b1;
                    arr_rd_idx <= j_q;
                end
                ST_RD_A: begin
                    state_q    <= ST_RD_B;
                    arr_rd_en  <= 1'b1;
                    arr_rd_idx <= jNext_d;
                end
                ST_RD_B: begin
                    state_q <= ST_CMP;
                    a_q     <= arr_rd_data;
                end
                // Strict greater-than keeps equal keys in their original order.
                ST_CMP: begin
                    if (a_q > arr_rd_data) begin
                        state_q     <= ST_WR_A;
                        arr_wr_en   <= 1'b1;
                        arr_wr_idx  <= j_q;
                        arr_wr_data <= arr_rd_data;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_WR_A: begin
                    state_q     <= ST_WR_B;
                    arr_wr_en   <= 1'b1;
                    arr_wr_idx  <= jNext_d;
                    arr_wr_data <= a_q;
                end
                ST_WR_B: begin
                    state_q       <= ST_NEXT;
                    swap_count    <= swap_count + 1'b1;
                    passSwapped_q <= 1'b1;
                end
                ST_NEXT: begin
                    if (j_q == lastJ_d) begin
                        if (!passSwapped_q || lastPass_d) begin
                            state_q <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            state_q       <= ST_RD_A;
                            pass_q        <= pass_q + 1'b1;
                            j_q           <= '0;
                            passSwapped_q <= 1'b0;
                            arr_rd_en     <= 1'b1;
                            arr_rd_idx    <= '0;
                        end
                    end else begin
                        state_q    <= ST_RD_A;
                        j_q        <= jNext_d;
                        arr_rd_en  <= 1'b1;
                        arr_rd_idx <= jNext_d;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array8_sort_ctrl.sv
// Directed bench for array8_sort_ctrl with a behavioural 8-entry array beside it.
module tb_array8_sort_ctrl;
    import array8_sort_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] swap_count;
    logic       arr_en;
    logic       arr_wr_en;
    logic [2:0] arr_wr_idx;
    logic [7:0] arr_wr_data;
    logic       arr_rd_en;
    logic [2:0] arr_rd_idx;
    logic [7:0] arr_rd_data;

    logic       tbRdEn;
    logic [2:0] tbRdIdx;
    logic       rdEnA;
    logic [2:0] rdIdxA;
    logic [7:0] mem [8];
    logic       arrActive;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    int enCount     = 0;

    logic       prevWr;
    logic       prevRd;
    logic [2:0] prevRdIdx;
    logic [2:0] savedIdx;
    logic [7:0] savedA;

    int expSorted [8] = '{13, 13, 46, 85, 99, 120, 175, 236};

    array8_sort_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .arr_en     (arr_en),
        .arr_wr_en  (arr_wr_en),
        .arr_wr_idx (arr_wr_idx),
        .arr_wr_data(arr_wr_data),
        .arr_rd_en  (arr_rd_en),
        .arr_rd_idx (arr_rd_idx),
        .arr_rd_data(arr_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural array: preset load on enable only when inactive, registered read
    // data that is valid one cycle after a read enable and zero otherwise.
    assign rdEnA  = arr_rd_en | tbRdEn;
    assign rdIdxA = arr_rd_en ? arr_rd_idx : tbRdIdx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            arrActive   <= 1'b0;
            arr_rd_data <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            if (arr_en && !arrActive) begin
                arrActive <= 1'b1;
                for (int i = 0; i < 8; i++) mem[i] <= presetEntry(i);
            end else if (arr_wr_en && arrActive) begin
                mem[arr_wr_idx] <= arr_wr_data;
            end
            arr_rd_data <= rdEnA ? mem[rdIdxA] : 8'd0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Per-cycle protocol and swap-legitimacy monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            prevWr    = 1'b0;
            prevRd    = 1'b0;
            prevRdIdx = '0;
        end else begin
            if (done)   doneCount++;
            if (arr_en) enCount++;
            checkOutput("rd_wr_exclusive", 32'(arr_rd_en & arr_wr_en), 32'd0);
            if (arr_rd_en && prevRd)
                checkOutput("rdB_idx", 32'(arr_rd_idx), 32'(3'(prevRdIdx + 3'd1)));
            if (arr_wr_en && !prevWr) begin
                checkOutput("wrA_idx_range", 32'(arr_wr_idx < 3'd7), 32'd1);
                checkOutput("wrA_data", 32'(arr_wr_data), 32'(mem[3'(arr_wr_idx + 3'd1)]));
                checkOutput("wrA_strict_order",
                            32'(mem[arr_wr_idx] > mem[3'(arr_wr_idx + 3'd1)]), 32'd1);
                savedIdx = arr_wr_idx;
                savedA   = mem[arr_wr_idx];
            end else if (arr_wr_en && prevWr) begin
                checkOutput("wrB_idx", 32'(arr_wr_idx), 32'(3'(savedIdx + 3'd1)));
                checkOutput("wrB_data", 32'(arr_wr_data), 32'(savedA));
            end
            prevWr    = arr_wr_en;
            prevRd    = arr_rd_en;
            prevRdIdx = arr_rd_idx;
        end
    end

    // Pulse start for one cycle; returns at the negedge inside LOAD.
    task automatic applyStimulus();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles with the accepting IDLE cycle as 1; caller is in LOAD (cycle 2).
    task automatic waitDone(output int cyc);
        cyc = 2;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic readEntry(input int idx, output logic [7:0] data);
        tbRdEn  = 1'b1;
        tbRdIdx = 3'(idx);
        @(negedge clk);
        tbRdEn  = 1'b0;
        data    = arr_rd_data;
        @(negedge clk);
    endtask

    task automatic checkSorted(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            readEntry(i, d);
            checkOutput($sformatf("%s_entry%0d", tag, i), 32'(d), 32'(expSorted[i]));
        end
    endtask

    initial begin
        int cyc;
        int doneBase;
        int enBase;
        int hits;

        start   = 1'b0;
        tbRdEn  = 1'b0;
        tbRdIdx = '0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({busy, done, swap_count, arr_en, arr_wr_en, arr_rd_en}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] test 1: first sort from preset contents");
        doneBase = doneCount;
        enBase   = enCount;
        applyStimulus();
        checkOutput("t1_busy_after_accept", 32'(busy), 32'd1);
        checkOutput("t1_arr_en_in_load", 32'(arr_en), 32'd1);
        waitDone(cyc);
        @(negedge clk);
        checkOutput("t1_busy_after_fin", 32'(busy), 32'd0);
        checkOutput("t1_done_one_cycle", 32'(done), 32'd0);
        checkOutput("t1_swap_count", 32'(swap_count), 32'd20);
        repeat (3) @(negedge clk);
        checkOutput("t1_arr_en_cycles", 32'(enCount - enBase), 32'd1);
        checkOutput("t1_done_pulses", 32'(doneCount - doneBase), 32'd1);
        checkSorted("t1");

        $display("[TB] test 2: re-sort an already sorted, active array");
        doneBase = doneCount;
        applyStimulus();
        waitDone(cyc);
        checkOutput("t2_cycles_to_done", 32'(cyc), 32'(3 + 4 * 7 + 2 * 0 + 1));
        repeat (3) @(negedge clk);
        checkOutput("t2_swap_count", 32'(swap_count), 32'd0);
        checkOutput("t2_done_pulses", 32'(doneCount - doneBase), 32'd1);
        checkSorted("t2");

        $display("[TB] test 3: start held high for the whole sort");
        doneBase = doneCount;
        enBase   = enCount;
        start    = 1'b1;
        @(negedge clk);
        waitDone(cyc);
        start = 1'b0;
        checkOutput("t3_cycles_to_done", 32'(cyc), 32'd32);
        repeat (5) @(negedge clk);
        checkOutput("t3_busy_idle", 32'(busy), 32'd0);
        checkOutput("t3_done_pulses", 32'(doneCount - doneBase), 32'd1);
        checkOutput("t3_arr_en_cycles", 32'(enCount - enBase), 32'd1);

        $display("[TB] test 4: reset during RD_B of the second pass");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus();
        hits = 0;
        cyc  = 0;
        while (hits < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (arr_rd_en && arr_rd_idx == 3'd1) hits++;
        end
        checkOutput("t4_reached_pass2_rdB", 32'(hits), 32'd3);
        doneBase = doneCount;
        reset = 1'b1;
        #1;
        checkOutput("t4_async_reset_outputs",
                    32'({busy, done, swap_count, arr_en, arr_wr_en, arr_rd_en}), 32'd0);
        checkOutput("t4_async_reset_idx_data",
                    32'({arr_wr_idx, arr_rd_idx, arr_wr_data}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t4_busy_after_abort", 32'(busy), 32'd0);
        checkOutput("t4_no_done_pulse", 32'(doneCount - doneBase), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
